// File: rtl/myminimac_mdio_slave_if.sv
// Signal bundle between the MDIO responder, the MDIO pad/master side and the PHY register bank.
interface myminimac_mdio_slave_if;
  logic        mdc_i;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        frame_err;

  modport slave (
    input  mdc_i, mdio_i, reg_rdata,
    output mdio_o, mdio_oe, reg_addr, reg_re, reg_we, reg_wdata, frame_err
  );

  modport master (
    output mdc_i, mdio_i, reg_rdata,
    input  mdio_o, mdio_oe, reg_addr, reg_re, reg_we, reg_wdata, frame_err
  );
endinterface

// File: rtl/myminimac_mdio_slave.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO in sys_clk, decodes frames and
// drives register-bank strobes and read data back onto MDIO.
module myminimac_mdio_slave #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic                   sys_clk,
  input logic                   sys_rst,
  myminimac_mdio_slave_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ST    = 3'd1;
  localparam logic [2:0] ST_OP    = 3'd2;
  localparam logic [2:0] ST_PHYAD = 3'd3;
  localparam logic [2:0] ST_REGAD = 3'd4;
  localparam logic [2:0] ST_TA    = 3'd5;
  localparam logic [2:0] ST_DATA  = 3'd6;

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_LEN);
  localparam logic [5:0] PRE_SAT = 6'd32;

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
  logic                   mdc_prev_q;
  logic                   mdc_edge, mdio_s;

  logic [2:0]  state_q, state_d;
  logic [5:0]  pre_q, pre_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_msb_q, op_msb_d;
  logic        is_read_q, is_read_d;
  logic        addressed_q, addressed_d;
  logic [4:0]  sh5_q, sh5_d;
  logic [15:0] shift_q, shift_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        reg_re_q, reg_re_d;
  logic        reg_we_q, reg_we_d;
  logic        frame_err_q, frame_err_d;
  logic        rdata_cap_q;

  assign mdc_edge = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
  assign mdio_s   = mdio_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    op_msb_d    = op_msb_q;
    is_read_d   = is_read_q;
    addressed_d = addressed_q;
    sh5_d       = sh5_q;
    shift_d     = shift_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_re_d    = 1'b0;
    reg_we_d    = 1'b0;
    frame_err_d = 1'b0;

    // Bank data lands two cycles after reg_re, long before the TA edges.
    if (rdata_cap_q) shift_d = bus.reg_rdata;

    if (mdc_edge) begin
      case (state_q)
        ST_IDLE: begin
          if (mdio_s) begin
            if (pre_q != PRE_SAT) pre_d = pre_q + 6'd1;
          end else if (pre_q >= PRE_MIN) begin
            state_d = ST_ST;
          end else begin
            pre_d = '0;
          end
        end
        ST_ST: begin
          if (mdio_s) begin
            state_d = ST_OP;
            cnt_d   = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            pre_d       = '0;
          end
        end
        ST_OP: begin
          if (cnt_q == 4'd0) begin
            op_msb_d = mdio_s;
            cnt_d    = 4'd1;
          end else if (op_msb_q != mdio_s) begin
            is_read_d = op_msb_q;
            state_d   = ST_PHYAD;
            cnt_d     = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            pre_d       = '0;
          end
        end
        ST_PHYAD: begin
          sh5_d = {sh5_q[3:0], mdio_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd4) begin
            addressed_d = ({sh5_q[3:0], mdio_s} == PHY_ADDR);
            state_d     = ST_REGAD;
            cnt_d       = '0;
          end
        end
        ST_REGAD: begin
          sh5_d = {sh5_q[3:0], mdio_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd4) begin
            reg_addr_d = {sh5_q[3:0], mdio_s};
            reg_re_d   = is_read_q & addressed_q;
            state_d    = ST_TA;
            cnt_d      = '0;
          end
        end
        ST_TA: begin
          cnt_d = cnt_q + 4'd1;
          if (is_read_q && addressed_q) begin
            if (cnt_q == 4'd0) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end else begin
              mdio_o_d = shift_q[15];
              shift_d  = {shift_q[14:0], 1'b0};
            end
          end
          if (cnt_q == 4'd1) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (is_read_q) begin
            if (addressed_q) begin
              mdio_o_d = shift_q[15];
              shift_d  = {shift_q[14:0], 1'b0};
            end
          end else begin
            shift_d = {shift_q[14:0], mdio_s};
          end
          if (cnt_q == 4'd15) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
            if (is_read_q && addressed_q) begin
              mdio_oe_d = 1'b0;
              mdio_o_d  = 1'b1;
            end
            if (!is_read_q && addressed_q) begin
              reg_wdata_d = {shift_q[14:0], mdio_s};
              reg_we_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          pre_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
      mdc_prev_q  <= 1'b0;
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      op_msb_q    <= 1'b0;
      is_read_q   <= 1'b0;
      addressed_q <= 1'b0;
      sh5_q       <= '0;
      shift_q     <= '0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_re_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_cap_q <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], bus.mdc_i};
      mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], bus.mdio_i};
      mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      op_msb_q    <= op_msb_d;
      is_read_q   <= is_read_d;
      addressed_q <= addressed_d;
      sh5_q       <= sh5_d;
      shift_q     <= shift_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_re_q    <= reg_re_d;
      reg_we_q    <= reg_we_d;
      frame_err_q <= frame_err_d;
      rdata_cap_q <= reg_re_q;
    end
  end

  assign bus.mdio_o    = mdio_o_q;
  assign bus.mdio_oe   = mdio_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.frame_err = frame_err_q;

endmodule
